// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, DIGIT bits per clock, with the
// borrow carried between cycles in a register. start/busy/done handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one DIGIT-wide slice subtracted per edge, N = WIDTH/DIGIT edges
// DONE  | done pulse; diff/bout/zero valid; returns to IDLE unconditionally
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam int RW = (WIDTH > DIGIT) ? (WIDTH - DIGIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic              borrow;
  logic [CW-1:0]     cnt;
  // Partial result: only the digits finished before the final step are kept;
  // the final step's digit joins them directly on the way into diff.
  logic [RW-1:0]     res_sh;
  logic [RW-1:0]     res_keep;
  logic [WIDTH-1:0]  res_next;
  logic [DIGIT:0]    step;

  // One digit of subtraction: MSB of the (DIGIT+1)-bit result is the borrow out.
  always_comb begin
    step = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
  end

  if (DIGIT == WIDTH) begin : g_single
    assign res_next = step[DIGIT-1:0];
    assign res_keep = res_sh;
  end else begin : g_multi
    // New digit enters at the MSB side; after N steps the LSB digit is at bit 0.
    assign res_next = {step[DIGIT-1:0], res_sh};
    assign res_keep = res_next[WIDTH-1:DIGIT];
  end

  // Sequencer and datapath: load on accepted start, step through N digits,
  // publish the result only on the final step so diff/zero never show partials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          borrow <= step[DIGIT];
          res_sh <= res_keep;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= res_next;
            bout  <= step[DIGIT];
            zero  <= (res_next == '0);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed 8-bit cases on DIGIT=1 and DIGIT=4
// instances, then randomized back-to-back traffic on four 16-bit instances
// (DIGIT 1, 2, 4, 16) checked against plain arithmetic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit instances
  logic [7:0] a8, b8;
  logic       bin8;
  logic       start1, start4;
  logic       busy1, done1, bout1, zero1;
  logic [7:0] diff1;
  logic       busy4, done4, bout4, zero4;
  logic [7:0] diff4;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a8), .b(b8), .bin(bin8),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a8), .b(b8), .bin(bin8),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
  );

  logic       sel4;
  logic       o_busy, o_done, o_bout, o_zero;
  logic [7:0] o_diff;
  assign o_busy = sel4 ? busy4 : busy1;
  assign o_done = sel4 ? done4 : done1;
  assign o_diff = sel4 ? diff4 : diff1;
  assign o_bout = sel4 ? bout4 : bout1;
  assign o_zero = sel4 ? zero4 : zero1;

  // 16-bit instances
  localparam int DG[4] = '{1, 2, 4, 16};
  localparam int NS[4] = '{16, 8, 4, 1};
  logic        start16;
  logic [15:0] a16, b16;
  logic        bin16;
  logic        busy16[4], done16[4], bout16[4], zero16[4];
  logic [15:0] diff16[4];

  for (genvar g = 0; g < 4; g++) begin : g_dut16
    serial_subtractor #(.WIDTH(16), .DIGIT(DG[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
      .busy(busy16[g]), .done(done16[g]), .diff(diff16[g]), .bout(bout16[g]), .zero(zero16[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Accept one operation on the selected 8-bit instance and check latency/result.
  task automatic op8(input logic use4, input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic tc, input int exp_lat, input logic [7:0] exp_diff,
                     input logic exp_bout, input logic exp_zero, input string tag);
    int lat;
    sel4 = use4;
    a8 = ta; b8 = tb_v; bin8 = tc;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    chk({tag, "_busy_start"}, o_busy, 1);
    chk({tag, "_done_start"}, o_done, 0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (o_done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_diff"}, o_diff, exp_diff);
    chk({tag, "_bout"}, o_bout, exp_bout);
    chk({tag, "_zero"}, o_zero, exp_zero);
    chk({tag, "_busy_done"}, o_busy, 1);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, o_done, 0);
    chk({tag, "_busy_drop"}, o_busy, 0);
    chk({tag, "_diff_hold"}, o_diff, exp_diff);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  logic [15:0] va[3200];
  logic [15:0] vb[3200];
  logic        vc[3200];
  int          ndone, lat, n, s, results;
  logic [15:0] ed;
  logic        eb;

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; start16 = 1'b0; sel4 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    #12;
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_diff1", diff1, 0);
    chk("rst_bout1", bout1, 0);
    chk("rst_zero1", zero1, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_diff16", diff16[3], 0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(1'b0, 8'h05, 8'h03, 1'b0, 8, 8'h02, 1'b0, 1'b0, "d1_5m3");
    op8(1'b0, 8'h03, 8'h05, 1'b0, 8, 8'hFE, 1'b1, 1'b0, "d1_3m5");
    op8(1'b0, 8'h00, 8'h00, 1'b1, 8, 8'hFF, 1'b1, 1'b0, "d1_0m0b");
    op8(1'b1, 8'hA7, 8'hA7, 1'b0, 2, 8'h00, 1'b0, 1'b1, "d4_eq");
    op8(1'b1, 8'h12, 8'h34, 1'b1, 2, 8'hDD, 1'b1, 1'b0, "d4_borrow");

    // Start pulses during RUN must be ignored.
    sel4 = 1'b0;
    a8 = 8'h9C; b8 = 8'h31; bin8 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    ndone = 0; lat = -1;
    for (int e = 1; e <= 14; e++) begin
      start1 = (e == 2 || e == 5);
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(posedge clk); #1;
      if (done1) begin
        ndone++;
        lat = e;
        chk("ign_diff", diff1, 8'h6B);
        chk("ign_bout", bout1, 0);
      end
    end
    start1 = 1'b0;
    chk("ign_done_count", ndone, 1);
    chk("ign_latency", lat, 8);

    // Asynchronous reset in the middle of a run.
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy1, 1);
    chk("pre_rst_diff_hold", diff1, 8'h6B);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_done", done1, 0);
    chk("arst_diff", diff1, 0);
    chk("arst_bout", bout1, 0);
    chk("arst_zero", zero1, 0);
    #3;
    rst_n = 1'b1;
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done1) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    op8(1'b0, 8'h10, 8'h01, 1'b0, 8, 8'h0F, 1'b0, 1'b0, "post_rst");

    // Randomized back-to-back traffic with start held high.
    a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
    va[0] = a16; vb[0] = b16; vc[0] = bin16;
    start16 = 1'b1;
    results = 0;
    for (int t = 0; t < 3000 && results < 1000; t++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        n = NS[g];
        if ((t % (n + 2)) == n) begin
          s = t - n;
          ed = va[s] - vb[s] - {15'b0, vc[s]};
          eb = ({1'b0, va[s]} < ({1'b0, vb[s]} + {16'b0, vc[s]}));
          chk("rnd_done", done16[g], 1);
          chk("rnd_diff", diff16[g], ed);
          chk("rnd_bout", bout16[g], eb);
          chk("rnd_zero", zero16[g], (ed == 16'h0));
          results++;
        end else begin
          chk("rnd_done_low", done16[g], 0);
        end
        chk("rnd_busy", busy16[g], ((t % (n + 2)) == (n + 1)) ? 0 : 1);
      end
      a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
      va[t + 1] = a16; vb[t + 1] = b16; vc[t + 1] = bin16;
    end
    start16 = 1'b0;
    chk("rnd_result_count", (results >= 1000) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
